level_loader: RTL and testbench

Parametrised brick-field loader for BrickBreaker. On a `start` pulse it walks every brick slot of the selected level in order. For each slot it presents the brick's screen coordinates, memory address and initial health, requests a draw, waits a fixed draw time, then pulses a write into brick memory. It sits between the game-control FSM, the brick RAM and the VGA draw engine, and supports multiple levels, restart, abort and optional skipping of empty slots.

---
 rtl/brick_pkg.sv | 19 +
 rtl/level_rom.sv | 43 ++++
 rtl/level_loader.sv | 114 +++++++++++
 tb/tb_level_loader.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/brick_pkg.sv
// rtl/brick_pkg.sv - shared brick-field constants and loader state encoding
package brick_pkg;

  localparam int GRID_X_DEF     = 16;
  localparam int BRICK_W_DEF    = 4;
  localparam int BRICK_H_DEF    = 2;
  localparam int NUM_BRICKS_DEF = 64;
  localparam int DRAW_DELAY_DEF = 16;
  localparam int HEALTH_W       = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_WAIT,
    S_LOAD,
    S_DONE
  } state_t;

endpackage

// File: rtl/level_rom.sv
// rtl/level_rom.sv - combinational level table: initial health per (level, slot)
module level_rom
  import brick_pkg::*;
#(
  parameter int NUM_BRICKS = NUM_BRICKS_DEF,
  parameter int GRID_X     = GRID_X_DEF,
  parameter int NUM_LEVELS = 3
) (
  input  logic [9:0]                    lvl,
  input  logic [$clog2(NUM_BRICKS)-1:0] idx,
  output logic [HEALTH_W-1:0]           health
);

  localparam int GX_LOG = $clog2(GRID_X);

  int slot;
  int row;

  always_comb begin
    slot   = int'(idx);
    row    = slot >> GX_LOG;
    health = '0;
    if (int'(lvl) < NUM_LEVELS) begin
      case (lvl)
        10'd0: begin
          case (slot)
            1:       health = HEALTH_W'(3);
            2:       health = HEALTH_W'(2);
            3:       health = HEALTH_W'(1);
            4:       health = HEALTH_W'(3);
            5:       health = HEALTH_W'(1);
            default: health = '0;
          endcase
        end
        10'd1:   health = HEALTH_W'(1);
        // rows cycle 3,2,1,0 so every fourth row is left empty
        10'd2:   health = HEALTH_W'(3 - (row % 4));
        default: health = '0;
      endcase
    end
  end

endmodule

// File: rtl/level_loader.sv
// rtl/level_loader.sv - walks every brick slot of a level: draw request, draw wait, RAM write
module level_loader
  import brick_pkg::*;
#(
  parameter int NUM_BRICKS = NUM_BRICKS_DEF,
  parameter int GRID_X     = GRID_X_DEF,
  parameter int BRICK_W    = BRICK_W_DEF,
  parameter int BRICK_H    = BRICK_H_DEF,
  parameter int Y_OFFSET   = 0,
  parameter int DRAW_DELAY = DRAW_DELAY_DEF,
  parameter int NUM_LEVELS = 3,
  parameter int SKIP_EMPTY = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic [9:0]          level_sel,
  output logic                draw,
  output logic                write_en,
  output logic                busy,
  output logic                done,
  output logic [9:0]          x_out,
  output logic [9:0]          y_out,
  output logic [9:0]          address,
  output logic [HEALTH_W-1:0] health
);

  localparam int IDX_W  = $clog2(NUM_BRICKS);
  localparam int CNT_W  = $clog2(DRAW_DELAY + 1);
  localparam int GX_LOG = $clog2(GRID_X);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BRICKS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAW_DELAY - 1);

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] idx;
  logic [9:0]       lvl;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             skip;

  level_rom #(
    .NUM_BRICKS(NUM_BRICKS),
    .GRID_X    (GRID_X),
    .NUM_LEVELS(NUM_LEVELS)
  ) u_rom (
    .lvl   (lvl),
    .idx   (idx),
    .health(health)
  );

  assign busy    = (state == S_PREP) || (state == S_WAIT) || (state == S_LOAD);
  assign done    = (state == S_DONE);
  assign accept  = start && ((state == S_IDLE) || (state == S_DONE));
  assign skip    = (SKIP_EMPTY != 0) && (health == '0);

  // GRID_X is a power of two, so the mask/shift are just column/row bit slices of idx
  assign address = 10'(idx);
  assign x_out   = 10'((int'(idx) & (GRID_X - 1)) * BRICK_W);
  assign y_out   = 10'((int'(idx) >> GX_LOG) * BRICK_H + Y_OFFSET);

  always_comb begin
    state_nxt = state;
    draw      = 1'b0;
    write_en  = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) state_nxt = S_PREP;
      end
      S_PREP: begin
        draw      = !skip;
        state_nxt = skip ? S_LOAD : S_WAIT;
      end
      S_WAIT: begin
        if (cnt == CNT_LAST) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        write_en  = 1'b1;
        state_nxt = (idx == LAST_IDX) ? S_DONE : S_PREP;
      end
      default: state_nxt = S_IDLE;
    endcase
    // abort beats everything while loading, including a coincident start
    if (abort && busy) begin
      state_nxt = S_IDLE;
      draw      = 1'b0;
      write_en  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      idx   <= '0;
      lvl   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        idx <= '0;
        cnt <= '0;
        lvl <= (level_sel >= 10'(NUM_LEVELS)) ? 10'd0 : level_sel;
      end
      case (state)
        S_PREP:  cnt <= '0;
        S_WAIT:  cnt <= cnt + 1'b1;
        S_LOAD:  if (!abort && idx != LAST_IDX) idx <= idx + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_level_loader.sv
// tb/tb_level_loader.sv - bench for level_loader: default unit and a SKIP_EMPTY=1 unit
module tb_level_loader;

  localparam int NB = 64;
  localparam int DD = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_s[2];
  logic       abort_s[2];
  logic [9:0] sel_s[2];
  logic       draw_o[2];
  logic       we_o[2];
  logic       busy_o[2];
  logic       done_o[2];
  logic [9:0] x_o[2];
  logic [9:0] y_o[2];
  logic [9:0] addr_o[2];
  logic [1:0] h_o[2];

  int checks   = 0;
  int failures = 0;
  int mode[2];
  int t[2];
  int ml[2];
  int nd[2];
  int nw[2];
  int skipc[2];

  always #5 clk = ~clk;

  level_loader dut0 (
    .clk(clk), .reset(reset), .start(start_s[0]), .abort(abort_s[0]), .level_sel(sel_s[0]),
    .draw(draw_o[0]), .write_en(we_o[0]), .busy(busy_o[0]), .done(done_o[0]),
    .x_out(x_o[0]), .y_out(y_o[0]), .address(addr_o[0]), .health(h_o[0])
  );

  level_loader #(.SKIP_EMPTY(1)) dut1 (
    .clk(clk), .reset(reset), .start(start_s[1]), .abort(abort_s[1]), .level_sel(sel_s[1]),
    .draw(draw_o[1]), .write_en(we_o[1]), .busy(busy_o[1]), .done(done_o[1]),
    .x_out(x_o[1]), .y_out(y_o[1]), .address(addr_o[1]), .health(h_o[1])
  );

  task automatic chk(input string nm, input int u, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s unit%0d actual=%0d expected=%0d at %0t", nm, u, act, exp, $time);
    end
  endtask

  function automatic int h_of(input int lvl, input int s);
    if (lvl == 0) begin
      case (s)
        1: return 3;
        2: return 2;
        3: return 1;
        4: return 3;
        5: return 1;
        default: return 0;
      endcase
    end
    if (lvl == 1) return 1;
    if (lvl == 2) return 3 - ((s / 16) % 4);
    return 0;
  endfunction

  function automatic int slot_len(input int lvl, input int sk, input int s);
    return (sk != 0 && h_of(lvl, s) == 0) ? 2 : DD + 2;
  endfunction

  function automatic int total_len(input int lvl, input int sk);
    int acc = 0;
    for (int s = 0; s < NB; s++) acc += slot_len(lvl, sk, s);
    return acc;
  endfunction

  // Where a load is t cycles after its first PREP: which slot, and is this its draw or write cycle
  function automatic void expect_at(input int lvl, input int sk, input int tt,
                                    output bit eb, output bit ed, output bit ew, output int ei);
    int acc = 0;
    bit found = 0;
    eb = 0; ed = 0; ew = 0; ei = NB - 1;
    for (int s = 0; s < NB; s++) begin
      int len = slot_len(lvl, sk, s);
      if (!found && tt < acc + len) begin
        found = 1;
        eb = 1;
        ei = s;
        ed = (tt == acc) && (len != 2);
        ew = (tt == acc + len - 1);
      end
      acc += len;
    end
  endfunction

  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      bit eb, ed, ew;
      int ei, el;
      bit pos_ok;
      eb = 0; ed = 0; ew = 0; ei = 0; el = 0; pos_ok = 1;
      if (reset || mode[u] == 3) begin
        chk("reset_busy", u, busy_o[u], 0);
        chk("reset_done", u, done_o[u], 0);
      end else if (mode[u] == 0) begin
        pos_ok = 0;
        chk("abort_busy", u, busy_o[u], 0);
        chk("abort_done", u, done_o[u], 0);
      end else begin
        expect_at(ml[u], skipc[u], t[u], eb, ed, ew, ei);
        el = ml[u];
        chk("busy", u, busy_o[u], eb);
        chk("done", u, done_o[u], !eb);
      end
      chk("draw", u, draw_o[u], ed);
      chk("write_en", u, we_o[u], ew);
      if (pos_ok) begin
        chk("address", u, addr_o[u], ei);
        chk("x_out", u, x_o[u], (ei % 16) * 4);
        chk("y_out", u, y_o[u], (ei / 16) * 2);
        chk("health", u, h_o[u], h_of(el, ei));
      end
      if (draw_o[u] === 1'b1) nd[u]++;
      if (we_o[u] === 1'b1) nw[u]++;
      if (reset) begin
        mode[u] = 3;
      end else if (mode[u] == 1 && t[u] < total_len(ml[u], skipc[u])) begin
        if (abort_s[u]) mode[u] = 0;
        else t[u]++;
      end else if (start_s[u]) begin
        mode[u] = 1;
        t[u]    = 0;
        ml[u]   = (sel_s[u] >= 3) ? 0 : int'(sel_s[u]);
        nd[u]   = 0;
        nw[u]   = 0;
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    skipc[0] = 0; skipc[1] = 1;
    for (int u = 0; u < 2; u++) begin
      mode[u] = 3; t[u] = 0; ml[u] = 0; nd[u] = 0; nw[u] = 0;
      start_s[u] = 0; abort_s[u] = 0; sel_s[u] = '0;
    end
    reset = 1'b1;
    wait_cyc(3);
    chk("rst_address", 0, addr_o[0], 0);
    chk("rst_x", 0, x_o[0], 0);
    chk("rst_health", 0, h_o[0], 0);
    chk("rst_we", 1, we_o[1], 0);
    reset = 1'b0;

    chk("pin_total_full", 0, total_len(0, 0), 1152);
    chk("pin_total_skip", 1, total_len(0, 1), 208);
    chk("pin_h_l2_s16", 0, h_of(2, 16), 2);
    chk("pin_h_l2_s48", 0, h_of(2, 48), 0);

    // both units load level 0
    wait_cyc(2);
    start_s[0] = 1; start_s[1] = 1;
    wait_cyc(1);
    start_s[0] = 0; start_s[1] = 0;
    chk("first_prep_draw", 0, draw_o[0], 1);
    wait_cyc(72);
    chk("s4_address", 0, addr_o[0], 4);
    chk("s4_health", 0, h_o[0], 3);
    chk("s4_x", 0, x_o[0], 16);
    chk("s4_y", 0, y_o[0], 0);
    wait_cyc(234);
    chk("s17_x", 0, x_o[0], 4);
    chk("s17_y", 0, y_o[0], 2);
    chk("s17_health", 0, h_o[0], 0);
    chk("skip_draws", 1, nd[1], 5);
    chk("skip_writes", 1, nw[1], 64);
    chk("skip_done", 1, done_o[1], 1);
    start_s[0] = 1;
    wait_cyc(1);
    start_s[0] = 0;
    chk("midload_start_addr", 0, addr_o[0], 17);
    wait_cyc(844);
    chk("pre_done", 0, done_o[0], 0);
    wait_cyc(1);
    chk("done_at_1152", 0, done_o[0], 1);
    chk("full_draws", 0, nd[0], 64);
    chk("full_writes", 0, nw[0], 64);

    // reload level 2 from DONE, abort in WAIT of slot 10
    sel_s[0] = 10'd2; start_s[0] = 1;
    wait_cyc(1);
    start_s[0] = 0;
    wait_cyc(185);
    chk("pre_abort_writes", 0, nw[0], 10);
    abort_s[0] = 1;
    wait_cyc(1);
    abort_s[0] = 0;
    chk("abort_busy_drop", 0, busy_o[0], 0);
    wait_cyc(3);
    chk("post_abort_writes", 0, nw[0], 10);
    start_s[0] = 1;
    wait_cyc(1);
    start_s[0] = 0;
    chk("restart_addr", 0, addr_o[0], 0);
    wait_cyc(288);
    chk("l2_s16_health", 0, h_o[0], 2);
    chk("l2_s16_y", 0, y_o[0], 2);
    wait_cyc(269);
    chk("s30_load_we", 0, we_o[0], 1);
    chk("s30_addr", 0, addr_o[0], 30);
    #1 reset = 1'b1;
    #1;
    chk("async_we", 0, we_o[0], 0);
    chk("async_busy", 0, busy_o[0], 0);
    chk("async_addr", 0, addr_o[0], 0);
    wait_cyc(2);
    reset = 1'b0;
    wait_cyc(2);
    chk("post_reset_busy", 0, busy_o[0], 0);

    // out-of-range level falls back to level 0
    sel_s[0] = 10'd7; sel_s[1] = 10'd7;
    start_s[0] = 1; start_s[1] = 1;
    wait_cyc(1);
    start_s[0] = 0; start_s[1] = 0;
    wait_cyc(72);
    chk("sel7_s4_health", 0, h_o[0], 3);
    wait_cyc(140);
    chk("sel7_skip_draws", 1, nd[1], 5);
    chk("sel7_skip_writes", 1, nw[1], 64);
    wait_cyc(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
